shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin controller that shares a single WIDTH-bit storage register, built from the team's D flip-flop cells, among NREQ requesters. Each requester asks for the register, is granted exclusive ownership for a fixed window, has its data loaded, and receives a one-cycle acknowledge. It sits in front of the shared register bank and drives its din/load timing; the register's q and qbar are exported directly.

## Interface

- NREQ, 4: number of requesters; legal range 2..16.
- WIDTH, 8: data width of the shared register.
- HOLD, 2: extra cycles ownership is held after the load cycle; legal range 0..15.
- OW, $clog2(NREQ): derived owner index width; not to be overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately with no clock edge needed.
- req  input  NREQ  request per requester; level-sensitive.
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; all zero when idle.
- ack  output  NREQ  one-hot, one-cycle pulse: owner's data is now in q.
- owner  output  OW  index of the current or most recent owner.
- q  output  WIDTH  shared register contents.
- qbar  output  WIDTH  bitwise complement of q at all times.
- valid  output  1  high once any load has completed since reset.

## Operation

- Reset values: state IDLE, gnt=0, ack=0, owner=0, round-robin pointer ptr=0, q=0, qbar=all ones, valid=0, hold counter=0.
- IDLE: when req is non-zero, select the first set bit searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1. Register gnt to that one-hot bit, set owner to its index, go to LOAD. If req is zero, stay in IDLE.
- LOAD (one cycle): on the edge leaving LOAD, q <= wdata slice of owner, ack[owner] <= 1, valid <= 1, ptr <= (owner+1) mod NREQ. Go to HOLD with counter=HOLD, or to IDLE if HOLD=0, which also clears gnt on that edge.
- HOLD: gnt stays asserted. The counter decrements each edge; on the edge where it reaches 1, gnt clears and the state returns to IDLE.
- req is sampled only in IDLE. Deasserting req during LOAD or HOLD does not cancel the load or shorten the window.
- wdata is sampled only on the LOAD exit edge. A change before that edge is taken; a change after it is ignored.
- ack is cleared on every edge on which it is not newly set. At most one ack bit is ever high.
- q holds its value between loads. Requesters can read q while they are not the owner.
- Reset mid-operation (LOAD or HOLD): the sequence aborts, no ack is issued, and all reset values apply at once.

## Timing

- Edge k is the first edge at which req[i] is sampled high in IDLE with i winning.
- After edge k: gnt[i]=1 and owner=i.
- After edge k+1: q=wdata[i], qbar=~wdata[i], and ack[i]=1 for exactly one cycle.
- After edge k+1+HOLD: gnt=0. The grant lasts 1+HOLD cycles.
- There is one mandatory IDLE cycle between grants. The earliest next grant is after edge k+2+HOLD, so throughput is one load per HOLD+2 cycles.
- gnt is never non-zero in IDLE, and the register never changes outside the LOAD exit edge or reset.

## Test plan

1. Reset: pulse reset high for 3 ns mid-cycle. Required: q=0x00, qbar=0xFF, gnt=0000, ack=0000, valid=0 without waiting for a clock edge.
2. Single request (NREQ=4, WIDTH=8, HOLD=2): req=0100, wdata slice 2 = 0xA5.
   - After edge k: gnt=0100, owner=2.
   - After edge k+1: q=0xA5, qbar=0x5A, ack=0100 for one cycle, valid=1.
   - After edge k+3: gnt=0000.
3. Continuous contention: hold req=1111 from reset release. Required: grants 0001, 0010, 0100, 1000, 0001, with each new grant 4 cycles after the previous, and each ack in the matching bit.
4. Fairness: after owner 0 completes (ptr=1), assert req=0101. Required: gnt=0100 next, then gnt=0001.
5. Withdrawn request: req[1] drops during LOAD while wdata slice 1 = 0x3C. Required: q=0x3C, ack=0010 pulse, and the full 3-cycle grant still occurs.
6. Reset in HOLD: assert reset one cycle after ack. Required: gnt, ack and q clear immediately. After release, a pending req=1000 is granted from ptr=0 and yields gnt=1000.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin ownership of one shared WIDTH-bit register among NREQ requesters
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  parameter int OW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  valid
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;
  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
  logic [OW-1:0]     owner_q, owner_d, ptr_q, ptr_d, sel;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d, found;
  logic [3:0]        cnt_q, cnt_d;
  // first requester at or after the round-robin pointer, wrapping around
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int j = 0; j < NREQ; j++)
      if (!found && req[(int'(ptr_q) + j) % NREQ]) begin
        found = 1'b1;
        sel = OW'((int'(ptr_q) + j) % NREQ);
      end
  end
  // grant, load, hold-window sequencing; ack is a single-edge pulse
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ack_d = '0;
    owner_d = owner_q;
    ptr_d = ptr_q;
    data_d = data_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (found) begin
        state_d = S_LOAD;
        gnt_d = NREQ'(1) << sel;
        owner_d = sel;
      end
      S_LOAD: begin
        data_d = wdata[owner_q*WIDTH +: WIDTH];
        ack_d[owner_q] = 1'b1;
        valid_d = 1'b1;
        ptr_d = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;
        state_d = (HOLD == 0) ? S_IDLE : S_HOLD;
        gnt_d = (HOLD == 0) ? '0 : gnt_q;
        cnt_d = 4'(HOLD);
      end
      S_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          gnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign gnt = gnt_q;
  assign ack = ack_q;
  assign owner = owner_q;
  assign q = data_q;
  assign qbar = ~data_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: scenario tasks plus an ack scoreboard for shared_reg_arbiter
module tb_shared_reg_arbiter;
  logic        clk, reset;
  logic [3:0]  req, gnt, ack;
  logic [31:0] wdata;
  logic [1:0]  owner;
  logic [7:0]  q, qbar;
  logic        valid;
  int passed = 0;
  int total = 0;
  typedef struct {int idx; logic [7:0] data;} exp_t;
  exp_t sb[$];

  shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(2)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
    .owner(owner), .q(q), .qbar(qbar), .valid(valid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // every ack must match the oldest expected load, in bit, owner and register value
  always @(negedge clk) begin
    if (!reset && ack !== 4'b0) begin
      total++;
      if (sb.size() == 0) $display("FAIL ack_unexpected ack=%b q=%h", ack, q);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (ack !== (4'b1 << e.idx) || owner !== 2'(e.idx) || q !== e.data || qbar !== ~e.data)
          $display("FAIL ack_load ack=%b owner=%0d q=%h qbar=%h exp_idx=%0d exp_q=%h", ack, owner, q, qbar, e.idx, e.data);
        else passed++;
      end
    end
  end

  task automatic test_reset;
    reset = 1; req = 0; wdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    total++;
    if (q !== 8'h00 || qbar !== 8'hFF || gnt !== 4'b0 || ack !== 4'b0 || valid !== 1'b0 || owner !== 2'd0)
      $display("FAIL reset_values q=%h qbar=%h gnt=%b ack=%b valid=%b owner=%0d", q, qbar, gnt, ack, valid, owner);
    else passed++;
    #2 reset = 0;
  endtask

  task automatic test_single;
    @(negedge clk);
    req = 4'b0100;
    wdata[16 +: 8] = 8'hA5;
    sb.push_back('{2, 8'hA5});
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || owner !== 2'd2) $display("FAIL single_grant gnt=%b owner=%0d exp 0100/2", gnt, owner);
    else passed++;
    req = 0;
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || gnt !== 4'b0100 || qbar !== 8'h5A) $display("FAIL single_load valid=%b gnt=%b qbar=%h", valid, gnt, qbar);
    else passed++;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || ack !== 4'b0) $display("FAIL single_hold gnt=%b ack=%b exp 0100/0000", gnt, ack);
    else passed++;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || q !== 8'hA5) $display("FAIL single_release gnt=%b q=%h exp 0000/a5", gnt, q);
    else passed++;
  endtask

  task automatic test_contention;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
    @(negedge clk);
    reset = 0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) sb.push_back('{n % 4, 8'h10 + 8'(n % 4)});
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++;
      if (gnt !== (4'b1 << (n % 4))) $display("FAIL contend_grant%0d gnt=%b exp=%b", n, gnt, 4'b1 << (n % 4));
      else passed++;
      if (n == 4) break;
      repeat (3) @(negedge clk);
      total++;
      if (gnt !== 4'b0) $display("FAIL contend_idle%0d gnt=%b exp 0000", n, gnt);
      else passed++;
    end
    req = 0;
    repeat (3) @(negedge clk);
    total++;
    if (gnt !== 4'b0) $display("FAIL contend_end gnt=%b exp 0000", gnt);
    else passed++;
  endtask

  task automatic test_fairness;
    req = 4'b0101;
    wdata[0 +: 8] = 8'hC0;
    wdata[16 +: 8] = 8'hC2;
    sb.push_back('{2, 8'hC2});
    sb.push_back('{0, 8'hC0});
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) $display("FAIL fair_first gnt=%b exp 0100", gnt);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if (gnt !== 4'b0001) $display("FAIL fair_second gnt=%b exp 0001", gnt);
    else passed++;
    req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_withdrawn;
    req = 4'b0010;
    wdata[8 +: 8] = 8'h77;
    sb.push_back('{1, 8'h3C});
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) $display("FAIL withdraw_grant gnt=%b exp 0010", gnt);
    else passed++;
    req = 0;
    wdata[8 +: 8] = 8'h3C;
    @(negedge clk);
    wdata[8 +: 8] = 8'h99;
    total++;
    if (gnt !== 4'b0010) $display("FAIL withdraw_load gnt=%b exp 0010", gnt);
    else passed++;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) $display("FAIL withdraw_hold gnt=%b exp 0010", gnt);
    else passed++;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || q !== 8'h3C) $display("FAIL withdraw_end gnt=%b q=%h exp 0000/3c", gnt, q);
    else passed++;
  endtask

  task automatic test_reset_hold;
    req = 4'b0010;
    wdata[8 +: 8] = 8'h5E;
    sb.push_back('{1, 8'h5E});
    @(negedge clk);
    req = 0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1;
    req = 4'b1000;
    wdata[24 +: 8] = 8'hD3;
    #1;
    total++;
    if (gnt !== 4'b0 || ack !== 4'b0 || q !== 8'h00 || qbar !== 8'hFF || valid !== 1'b0)
      $display("FAIL hold_reset gnt=%b ack=%b q=%h qbar=%h valid=%b", gnt, ack, q, qbar, valid);
    else passed++;
    @(negedge clk);
    reset = 0;
    sb.push_back('{3, 8'hD3});
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || owner !== 2'd3) $display("FAIL hold_regrant gnt=%b owner=%0d exp 1000/3", gnt, owner);
    else passed++;
    req = 0;
    repeat (3) @(negedge clk);
    total++;
    if (gnt !== 4'b0 || q !== 8'hD3) $display("FAIL hold_end gnt=%b q=%h exp 0000/d3", gnt, q);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_fairness;
    test_withdrawn;
    test_reset_hold;
    @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL missing_acks pending=%0d exp 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
